// File: rtl/tiled_matrix_multiplier.sv
// Tiled N x N signed matrix multiply over one single-port RAM,
// driving a 2x2 base multiplier with overflow and timeout checks.
module tiled_matrix_multiplier #(
  parameter int DATA_W  = 32,
  parameter int N       = 4,
  parameter int ADDR_W  = 9,
  parameter int A_BASE  = 0,
  parameter int B_BASE  = 64,
  parameter int C_BASE  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                start_mac,
  input  logic                done_mac,
  output logic [4*DATA_W-1:0] mac_a,
  output logic [4*DATA_W-1:0] mac_b,
  input  logic [4*DATA_W-1:0] mac_c
);

  localparam int NB = N / 2;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, CLR, LOAD, MSTART, MWAIT,
    ACC, WRITE, NEXT, FIN, ABORT
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0]     bi, bj, bk;
  logic [3:0]        ld_cnt;
  logic [1:0]        wr_cnt;
  logic [TW-1:0]     tmo;
  logic [DATA_W-1:0] op [8];
  logic [DATA_W-1:0] acc [4];
  logic [DATA_W-1:0] c_q [4];
  logic [DATA_W-1:0] sum [4];
  logic [3:0]        ovf;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              last_k, last_blk;

  assign last_k   = (bk == BW'(NB - 1));
  assign last_blk = (bi == BW'(NB - 1)) &&
                    (bj == BW'(NB - 1));

  // Slots 0..3 are the A sub-block, 4..7 the B sub-block.
  always_comb begin
    if (!ld_cnt[2])
      rd_addr = ADDR_W'(A_BASE
        + (2 * int'(bi) + int'(ld_cnt[1])) * N
        + 2 * int'(bk) + int'(ld_cnt[0]));
    else
      rd_addr = ADDR_W'(B_BASE
        + (2 * int'(bk) + int'(ld_cnt[1])) * N
        + 2 * int'(bj) + int'(ld_cnt[0]));
  end

  assign wr_addr = ADDR_W'(C_BASE
    + (2 * int'(bi) + int'(wr_cnt[1])) * N
    + 2 * int'(bj) + int'(wr_cnt[0]));

  assign mac_a = {op[3], op[2], op[1], op[0]};
  assign mac_b = {op[7], op[6], op[5], op[4]};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = acc[i] + c_q[i];
      ovf[i] = (acc[i][DATA_W-1] == c_q[i][DATA_W-1])
            && (sum[i][DATA_W-1] != acc[i][DATA_W-1]);
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    start_mac = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CLR;
      end
      CLR: state_nx = LOAD;
      LOAD: begin
        if (ld_cnt != 4'd8) ram_addr = rd_addr;
        else                state_nx = MSTART;
      end
      MSTART: begin
        start_mac = 1'b1;
        state_nx  = MWAIT;
      end
      MWAIT: begin
        if (done_mac)                     state_nx = ACC;
        else if (tmo == TW'(TIMEOUT - 1)) state_nx = ABORT;
      end
      ACC: state_nx = last_k ? WRITE : LOAD;
      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = acc[wr_cnt];
        if (wr_cnt == 2'd3) state_nx = NEXT;
      end
      NEXT: state_nx = last_blk ? FIN : CLR;
      FIN, ABORT: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      err    <= 1'b0;
      bi     <= '0;
      bj     <= '0;
      bk     <= '0;
      ld_cnt <= '0;
      wr_cnt <= '0;
      tmo    <= '0;
      for (int i = 0; i < 8; i++) op[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          err <= 1'b0;
          bi  <= '0;
          bj  <= '0;
          bk  <= '0;
        end
        CLR: begin
          for (int i = 0; i < 4; i++) acc[i] <= '0;
          ld_cnt <= '0;
        end
        LOAD: begin
          // RAM data lags its address by one cycle.
          if (ld_cnt != 4'd0)
            op[ld_cnt[2:0] - 3'd1] <= ram_rdata;
          ld_cnt <= ld_cnt + 4'd1;
        end
        MSTART: tmo <= '0;
        MWAIT: begin
          if (done_mac)
            for (int i = 0; i < 4; i++)
              c_q[i] <= mac_c[i*DATA_W +: DATA_W];
          else
            tmo <= tmo + TW'(1);
        end
        ACC: begin
          for (int i = 0; i < 4; i++) acc[i] <= sum[i];
          if (|ovf) err <= 1'b1;
          if (!last_k) begin
            bk     <= bk + BW'(1);
            ld_cnt <= '0;
          end
          wr_cnt <= '0;
        end
        WRITE: wr_cnt <= wr_cnt + 2'd1;
        NEXT: begin
          bk <= '0;
          if (bj == BW'(NB - 1)) begin
            bj <= '0;
            bi <= bi + BW'(1);
          end else begin
            bj <= bj + BW'(1);
          end
        end
        ABORT: err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// Randomised bench for tiled_matrix_multiplier: RAM and 2x2 MAC models,
// plain-arithmetic reference for C and the sticky overflow flag.
module tb_tiled_matrix_multiplier;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int AW  = 9;
  localparam int AB  = 0;
  localparam int BB  = 64;
  localparam int CB  = 128;
  localparam int TMO = 255;
  localparam int NB  = N / 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          start_mac, done_mac;
  logic [4*DW-1:0] mac_a, mac_b, mac_c;

  always #5 clk = ~clk;

  tiled_matrix_multiplier #(
    .DATA_W(DW), .N(N), .ADDR_W(AW),
    .A_BASE(AB), .B_BASE(BB), .C_BASE(CB),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .start_mac(start_mac), .done_mac(done_mac),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c)
  );

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [DW-1:0] cm [N*N];
  logic [DW-1:0] exp_c [N*N];
  bit            exp_err;
  bit            cm_clr = 1'b0;
  int            wr_n = 0, bad_n = 0;
  int            n_chk = 0, n_err = 0;
  int            mac_lat = 3;
  bit            mac_hang = 1'b0;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    int ia;
    ia = int'(a);
    if (ia >= AB && ia < AB + N*N) return ma[(ia-AB)/N][(ia-AB)%N];
    if (ia >= BB && ia < BB + N*N) return mb[(ia-BB)/N][(ia-BB)%N];
    if (ia >= CB && ia < CB + N*N) return cm[ia-CB];
    return '0;
  endfunction

  always @(posedge clk) begin
    ram_rdata <= rd_word(ram_addr);
    if (cm_clr) begin
      for (int i = 0; i < N*N; i++) cm[i] <= 32'hDEADBEEF;
    end else if (ram_we) begin
      wr_n <= wr_n + 1;
      if (int'(ram_addr) >= CB && int'(ram_addr) < CB + N*N)
        cm[int'(ram_addr) - CB] <= ram_wdata;
      else
        bad_n <= bad_n + 1;
    end
  end

  function automatic logic [4*DW-1:0] mul2(input logic [4*DW-1:0] a,
                                           input logic [4*DW-1:0] b);
    logic [DW-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
    {a22, a21, a12, a11} = a;
    {b22, b21, b12, b11} = b;
    return {a21*b12 + a22*b22, a21*b11 + a22*b21,
            a11*b12 + a12*b22, a11*b11 + a12*b21};
  endfunction

  // Base multiplier: done_mac in the mac_lat-th cycle after start_mac,
  // garbage on mac_c at every other time.
  logic [4*DW-1:0] mc_q;
  int              m_cnt;
  bit              m_pend;
  always @(posedge clk) begin
    done_mac <= 1'b0;
    mac_c    <= {$urandom, $urandom, $urandom, $urandom};
    if (rst) begin
      m_pend <= 1'b0;
    end else if (start_mac && !mac_hang) begin
      mc_q <= mul2(mac_a, mac_b);
      if (mac_lat <= 1) begin
        done_mac <= 1'b1;
        mac_c    <= mul2(mac_a, mac_b);
      end else begin
        m_pend <= 1'b1;
        m_cnt  <= mac_lat - 1;
      end
    end else if (m_pend) begin
      if (m_cnt == 1) begin
        done_mac <= 1'b1;
        mac_c    <= mc_q;
        m_pend   <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic fill(input int mode);
    int v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = (r == c) ? 32'd1 : 32'd0;
        case (mode)
          0: begin
            v = int'($urandom_range(0, 200)) - 100;
            ma[r][c] = v;
            v = int'($urandom_range(0, 200)) - 100;
            mb[r][c] = v;
          end
          1: begin
            ma[r][c] = $urandom;
            mb[r][c] = $urandom;
          end
          2: begin
            ma[r][c] = r + c;
            mb[r][c] = r - c;
          end
          3: ma[r][c] = r * N + c + 1;
          default: ;
        endcase
      end
    if (mode == 4) ma[0][0] = 32'h7FFFFFFF;
    if (mode == 5) begin
      ma[0][0] = 32'h7FFFFFFF;
      ma[0][2] = 32'h7FFFFFFF;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mb[r][c] = '0;
      mb[0][0] = 32'd1;
      mb[2][0] = 32'd1;
    end
  endtask

  // C[i][j] as a sum of per-k-block partial products, each partial
  // wrapping to DW bits, with signed overflow tracked on every add.
  task automatic ref_model();
    logic [DW-1:0] a, p;
    longint        s;
    longint        lim;
    lim     = 64'sd2147483647;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a = '0;
        for (int kb = 0; kb < NB; kb++) begin
          p = ma[i][2*kb] * mb[2*kb][j]
            + ma[i][2*kb+1] * mb[2*kb+1][j];
          s = longint'($signed(a)) + longint'($signed(p));
          if (s > lim || s < -lim - 1) exp_err = 1'b1;
          a = s[31:0];
        end
        exp_c[i*N + j] = a;
      end
  endtask

  task automatic run_check(input string tag, input int lat, input bit poke);
    int cyc, ndone, nlow, w0, b0, want;
    ref_model();
    mac_lat  = lat;
    mac_hang = 1'b0;
    @(negedge clk) cm_clr = 1'b1;
    @(negedge clk) cm_clr = 1'b0;
    w0 = wr_n;
    b0 = bad_n;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0; ndone = 0; nlow = 0;
    while (ndone == 0 && cyc < 5000) begin
      cyc++;
      if (cyc == 1) chk({tag, "_err_clr"}, err, 0);
      if (done) ndone++;
      else if (!busy) nlow++;
      start = poke && (cyc == 30);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    want = NB * NB * (1 + NB * (9 + 1 + lat + 1) + 4 + 1) + 1;
    chk({tag, "_cycles"}, cyc, want);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busy_gap"}, nlow, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_writes"}, wr_n - w0, N * N);
    chk({tag, "_bad_wr"}, bad_n - b0, 0);
    for (int i = 0; i < N*N; i++)
      chk($sformatf("%s_c%0d", tag, i), cm[i], exp_c[i]);
  endtask

  task automatic run_timeout(input string tag);
    int cyc, smac, dcyc, w0;
    cyc = 0; smac = -1; dcyc = -1;
    mac_hang = 1'b1;
    w0 = wr_n;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (dcyc < 0 && cyc < 2000) begin
      cyc++;
      if (start_mac) smac = cyc;
      if (done) dcyc = cyc;
      @(negedge clk);
    end
    chk({tag, "_delay"}, dcyc - smac, TMO + 1);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_writes"}, wr_n - w0, 0);
    chk({tag, "_busy"}, busy, 0);
    mac_hang = 1'b0;
  endtask

  task automatic reset_in_mwait();
    int cyc, w0, nd;
    mac_lat = 60;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!start_mac && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("rstm_reach", start_mac, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_outs",
        {busy, done, err, ram_we, start_mac, ram_addr, ram_wdata}, 0);
    rst = 1'b0;
    w0 = wr_n;
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("rstm_quiet", nd, 0);
    chk("rstm_writes", wr_n - w0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, err, ram_we, start_mac}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_mac", {mac_a, mac_b} == '0, 1);
    rst = 1'b0;
    @(negedge clk);

    fill(3); run_check("ident", 3, 1'b0);
    fill(2); run_check("rpc", 2, 1'b0);
    fill(4); run_check("ovf0", 1, 1'b0);
    chk("ovf0_c00", cm[0], 32'h7FFFFFFF);
    chk("ovf0_errflag", err, 0);
    fill(5); run_check("ovf1", 4, 1'b0);
    chk("ovf1_c00", cm[0], 32'hFFFFFFFE);
    chk("ovf1_errflag", err, 1);
    for (int i = 0; i < 5; i++) begin
      fill(i % 2);
      run_check($sformatf("rnd%0d", i), int'($urandom_range(1, 6)),
                i == 1);
    end

    run_timeout("tmo");
    fill(0); run_check("restart", 2, 1'b1);
    run_timeout("tmo2");
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_err_clr", err, 0);

    fill(1);
    reset_in_mwait();
    run_check("post_rst", 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tiled_matrix_multiplier.md
Name: tiled_matrix_multiplier

Overview:
- Parametrised successor to the fixed 2x2 multiplier datapath: computes C = A x B for N x N signed matrices held in one single-port RAM.
- Tiles the work into 2x2 blocks and drives the existing 2x2 base multiplier through its start/done handshake.
- Accumulates the partial block products internally and writes C back to RAM.
- Adds overflow detection and a MAC-timeout abort.

Parameters:
- DATA_W, 32, element width, two's complement.
- N, 4, matrix dimension; even, >= 2.
- ADDR_W, 9, RAM address width.
- A_BASE, 0, word address of A[0][0].
- B_BASE, 64, word address of B[0][0].
- C_BASE, 128, word address of C[0][0].
- TIMEOUT, 255, maximum cycles spent waiting for done_mac.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until the done pulse.
- done  out  1  one-cycle pulse on completion or abort.
- err  out  1  sticky error flag; cleared when the next start is accepted.
- ram_addr  out  ADDR_W  RAM word address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid 1 cycle after its address.
- start_mac  out  1  one-cycle start pulse to the 2x2 base multiplier.
- done_mac  in  1  base multiplier completion pulse.
- mac_a  out  4*DATA_W  packed a11,a12,a21,a22 (a11 in LSBs); held stable from start_mac until done_mac.
- mac_b  out  4*DATA_W  packed b11,b12,b21,b22, same packing as mac_a.
- mac_c  in  4*DATA_W  packed c11,c12,c21,c22; valid in the done_mac cycle.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy, done, err, ram_we, start_mac all 0; ram_addr, ram_wdata 0.
  - Block counters and accumulators cleared.
- Reset mid-operation has the same effect. No further RAM writes occur; partially written C is left as is.
- Storage layout: element M[r][c] at M_BASE + r*N + c, row-major, for M in {A, B, C}.
- Block counters bi, bj, bk each run 0..N/2-1. Block loop order is bi outer, bj middle, bk inner.
- FSM states:
  - IDLE: start=1 moves to CLR; busy <= 1 and err <= 0.
  - CLR: the 4 accumulators are zeroed.
  - LOAD: 8 consecutive read addresses, one per cycle:
    - A[2bi][2bk], A[2bi][2bk+1], A[2bi+1][2bk], A[2bi+1][2bk+1];
    - then B[2bk][2bj], B[2bk][2bj+1], B[2bk+1][2bj], B[2bk+1][2bj+1].
    - Each read is captured one cycle later, so LOAD takes 9 cycles; the last is capture-only.
  - MSTART: start_mac=1 for exactly one cycle; the timeout counter is cleared.
  - MWAIT:
    - Waits for done_mac while the timeout counter increments.
    - done_mac moves to ACC.
    - If the counter reaches TIMEOUT first, go to ABORT.
  - ACC:
    - acc_xy <= acc_xy + c_xy, modulo 2^DATA_W.
    - Signed overflow (operands have the same sign, result sign differs) sets err. Computation continues with the wrapped value.
    - If bk < N/2-1: bk++ and go to LOAD. Otherwise go to WRITE.
  - WRITE: 4 cycles with ram_we=1, writing C[2bi][2bj], C[2bi][2bj+1], C[2bi+1][2bj], C[2bi+1][2bj+1] from acc11, acc12, acc21, acc22.
  - NEXT: bk <= 0 and bj advances, wrapping into bi.
    - More blocks remain: go to CLR.
    - Last block done: go to FIN.
  - FIN: done=1 for 1 cycle; busy falls in the same cycle; return to IDLE.
  - ABORT: err <= 1, done=1 for 1 cycle, busy falls, return to IDLE; no C writes for the current block.
- start while busy has no effect.
- done_mac seen outside MWAIT is ignored.
- ram_we is 0 in every state except WRITE.
- Cycle count per block = 1 + (N/2)*(9 + 1 + Lmac + 1) + 4 + 1, where Lmac is the MWAIT cycles up to and including the done_mac cycle.
- Total cycles ≈ (N/2)^2 x the per-block count + 1 (FIN).

Test Plan:
- N=2: A = [[1,2],[3,4]], B = identity, MAC latency 3 -> C at 128..131 = 1,2,3,4. Exactly one done pulse, err=0, total cycles match the formula.
- N=4: A[r][c] = r+c, B[r][c] = r-c -> all 16 C words match a software reference model; ram_we never high outside C_BASE..C_BASE+15.
- Overflow: A[0][0] = 0x7FFFFFFF, B = identity, N=2 -> C[0][0] = 0x7FFFFFFF and err=0. Then set mac_c c11 to return 0x7FFFFFFF twice via N=4 tiling -> err=1 at done, C[0][0] = 0xFFFFFFFE.
- Timeout: done_mac held low -> done pulses exactly TIMEOUT cycles after start_mac (+1 for ABORT), err=1, no RAM writes, busy=0 afterwards.
- start pulsed during busy and again after done -> first extra pulse ignored; second pulse clears err and starts a fresh run.
- rst asserted during MWAIT -> all outputs 0 on the next edge; a subsequent start completes normally.
